// File: rtl/uart_word_tx_arbiter.sv
//==============================================================================
// Module      : uart_word_tx_arbiter
// Description : Round-robin arbiter that shares one byte-level UART
//               transmitter between up to four requesters. Each granted
//               16-bit word is latched and sent MSB byte first, then LSB
//               byte, and the requester receives a one-cycle ack.
//               Optional macro UART_ARB_ID_HEADER_EN prefixes every word
//               with a source-ID header byte {6'b101010, gnt[1:0]}.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_word_tx_arbiter #(
  parameter int NUM_REQ = 4  // legal range 2..4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic                   tx_dv,
  output logic [7:0]             tx_byte,
  input  logic                   tx_active,
  input  logic                   tx_done
);

  // Encodings are fixed so the header states can vanish from the default
  // build without renumbering the rest of the machine.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
`ifdef UART_ARB_ID_HEADER_EN
    ST_HDR_SEND = 3'd1,
    ST_HDR_WAIT = 3'd2,
`endif
    ST_MSB_SEND = 3'd3,
    ST_MSB_WAIT = 3'd4,
    ST_LSB_SEND = 3'd5,
    ST_LSB_WAIT = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam logic [5:0] HDR_TAG = 6'b101010;

  state_t               state_q, state_d;
  logic [15:0]          word_q,  word_d;
  logic [1:0]           gnt_q,   gnt_d;
  logic [1:0]           rr_q,    rr_d;
  logic [NUM_REQ-1:0]   ack_q,   ack_d;
  logic                 busy_q,  busy_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;

  // Requests and words padded to four lanes so a 2-bit index is always in
  // range regardless of NUM_REQ; unused lanes never request.
  logic [3:0]           req_pad;
  logic [15:0]          data_pad [4];
  logic [3:0]           ack_pad;

  logic                 win_found;
  logic [1:0]           win_idx;
  logic [2:0]           cand_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NUM_REQ) begin : g_live
        assign req_pad[gi]  = req[gi];
        assign data_pad[gi] = req_data[16*gi +: 16];
      end else begin : g_tie
        assign req_pad[gi]  = 1'b0;
        assign data_pad[gi] = 16'h0000;
      end
    end
  endgenerate

  // Round-robin search: first asserted request at or after rr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    cand_sum  = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_q} + 3'(k);
      if (cand_sum >= 3'(NUM_REQ)) begin
        cand_sum = cand_sum - 3'(NUM_REQ);
      end
      if (!win_found && req_pad[cand_sum[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[1:0];
      end
    end
  end

  // Next-state and registered-output logic; every output is computed one
  // cycle ahead so nothing combinational reaches the ports.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    ack_pad   = 4'b0000;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;

    case (state_q)
      ST_IDLE: begin
        // tx_active guard also covers a byte left in flight by a reset.
        if (win_found && !tx_active) begin
          word_d  = data_pad[win_idx];
          gnt_d   = win_idx;
          tx_dv_d = 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
          state_d   = ST_HDR_SEND;
          tx_byte_d = {HDR_TAG, win_idx};
`else
          state_d   = ST_MSB_SEND;
          tx_byte_d = data_pad[win_idx][15:8];
`endif
        end
      end
`ifdef UART_ARB_ID_HEADER_EN
      ST_HDR_SEND: state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        if (tx_done) begin
          state_d   = ST_MSB_SEND;
          tx_dv_d   = 1'b1;
          tx_byte_d = word_q[15:8];
        end
      end
`endif
      ST_MSB_SEND: state_d = ST_MSB_WAIT;
      ST_MSB_WAIT: begin
        if (tx_done) begin
          state_d   = ST_LSB_SEND;
          tx_dv_d   = 1'b1;
          tx_byte_d = word_q[7:0];
        end
      end
      ST_LSB_SEND: state_d = ST_LSB_WAIT;
      ST_LSB_WAIT: begin
        if (tx_done) begin
          state_d          = ST_DONE;
          ack_pad[gnt_q]   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rr_d    = (gnt_q == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    ack_d  = ack_pad[NUM_REQ-1:0];
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= 16'h0000;
      gnt_q     <= 2'd0;
      rr_q      <= 2'd0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_word_tx_arbiter
// Description : Self-checking bench for uart_word_tx_arbiter with a modelled
//               byte transmitter (20-cycle bytes). Honours the optional
//               UART_ARB_ID_HEADER_EN macro when forming expected bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_word_tx_arbiter;

  localparam int BYTE_CYC = 20;
`ifdef UART_ARB_ID_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] req_data = 64'h0;
  logic [3:0]  ack;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  int          byte_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  int          acks_q[$];
  logic [7:0]  bytes_q[$];

  logic prev_done = 1'b0, prev_busy = 1'b0, prev_dv = 1'b0;
  logic prev_ack = 1'b0, prev_rst = 1'b1;
  int v_dv_active = 0, v_dv_double = 0, v_ack_nodone = 0;
  int v_seq = 0, v_busy = 0, v_onehot = 0;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    int          n;
    logic [7:0]  ord;  // expected grant order, 2 bits per word, LSBs first
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  uart_word_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .busy      (busy),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  // Byte transmitter model: a start strobe while idle shifts for BYTE_CYC
  // cycles, then drops tx_active and pulses tx_done.
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_active) begin
      if (byte_cnt == 0) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt - 1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      byte_cnt  <= BYTE_CYC - 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, log bytes/acks, drop acked
  // requests, and check the cycle-level protocol.
  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      if (tx_dv) bytes_q.push_back(tx_byte);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          acks_q.push_back(i);
          req[i] = 1'b0;
        end
      end
    end
    if (!rst && !prev_rst) begin
      if (tx_dv && tx_active) v_dv_active++;
      if (tx_dv && prev_dv) v_dv_double++;
      if ((|ack) && !prev_done) v_ack_nodone++;
      if (prev_done && prev_busy && !(tx_dv ^ (|ack))) v_seq++;
      if (tx_dv && prev_busy && !prev_done) v_seq++;
      if ((tx_dv || (|ack)) && !busy) v_busy++;
      if (prev_ack && busy) v_busy++;
      if ($countones(ack) > 1) v_onehot++;
    end
    prev_done = tx_done;
    prev_busy = busy;
    prev_dv   = tx_dv;
    prev_ack  = |ack;
    prev_rst  = rst;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    cycle();
    cycle();
    rst = 1'b0;
    acks_q.delete();
    bytes_q.delete();
  endtask

  task automatic run_words(string tag, int n, int budget);
    int c = 0;
    while (acks_q.size() < n && c < budget) begin
      cycle();
      c++;
    end
    chk({tag, "_ack_count"}, acks_q.size(), n);
  endtask

  task automatic check_words(string tag, int n, logic [7:0] ord, logic [63:0] data);
    logic [7:0] exp_b[$];
    int id;
    for (int k = 0; k < n; k++) begin
      id = int'(ord[2*k +: 2]);
      chk({tag, "_ack_id"}, (k < acks_q.size()) ? acks_q[k] : 32'hDEAD, id);
      if (HDR_BYTES != 0) exp_b.push_back({6'b101010, 2'(id)});
      exp_b.push_back(data[16*id+8 +: 8]);
      exp_b.push_back(data[16*id +: 8]);
    end
    chk({tag, "_byte_count"}, bytes_q.size(), exp_b.size());
    for (int k = 0; k < exp_b.size(); k++) begin
      chk($sformatf("%s_byte%0d", tag, k),
          (k < bytes_q.size()) ? {24'h0, bytes_q[k]} : 32'hDEAD, {24'h0, exp_b[k]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{req: 4'b0001, data: 64'h0000_0000_0000_A55A, n: 1, ord: 8'h00};
    tbl[1] = '{req: 4'b1111, data: 64'h0304_0203_0102_0001, n: 4, ord: 8'hE4};
    tbl[2] = '{req: 4'b1010, data: 64'h7E81_0000_C3C3_0000, n: 2, ord: 8'h0D};
    tbl[3] = '{req: 4'b1100, data: 64'hF00F_0F0F_0000_0000, n: 2, ord: 8'h0E};

    // Reset values.
    cycle();
    cycle();
    chk("reset_ack", {28'h0, ack}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_tx_dv", {31'h0, tx_dv}, 32'h0);
    chk("reset_tx_byte", {24'h0, tx_byte}, 32'h0);

    // Table-driven word transfers, each starting from reset (rr = 0).
    for (int v = 0; v < 4; v++) begin
      do_reset();
      req_data = tbl[v].data;
      req      = tbl[v].req;
      run_words($sformatf("vec%0d", v), tbl[v].n, 400 * tbl[v].n);
      check_words($sformatf("vec%0d", v), tbl[v].n, tbl[v].ord, tbl[v].data);
      cycle();
      chk($sformatf("vec%0d_busy_after", v), {31'h0, busy}, 32'h0);
    end

    // Requester 0 re-requests at its ack while 1 and 2 wait: order 1,2,0.
    do_reset();
    req_data = 64'h4444_3333_2222_1111;
    req      = 4'b0001;
    run_words("starve_first", 1, 400);
    req = 4'b0111;
    acks_q.delete();
    bytes_q.delete();
    run_words("starve", 3, 1200);
    check_words("starve", 3, 8'h09, 64'h4444_3333_2222_1111);

    // Word data changes one cycle after grant; the latched word goes out.
    do_reset();
    req_data = 64'h0000_0000_0000_1234;
    req      = 4'b0001;
    for (int c = 0; c < 10 && bytes_q.size() == 0; c++) cycle();
    req_data[15:0] = 16'hFFFF;
    run_words("datachg", 1, 400);
    check_words("datachg", 1, 8'h00, 64'h0000_0000_0000_1234);

    // Reset during the MSB wait after rr has moved to 3.
    do_reset();
    req_data = 64'h3333_2222_0000_DEAD;
    req      = 4'b0100;
    run_words("prereset", 1, 400);
    acks_q.delete();
    bytes_q.delete();
    req = 4'b0001;
    for (int c = 0; c < 40 && bytes_q.size() < HDR_BYTES + 1; c++) cycle();
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1;
    req = 4'b1100;
    cycle();
    chk("midrst_ack", {28'h0, ack}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_tx_dv", {31'h0, tx_dv}, 32'h0);
    chk("midrst_tx_byte", {24'h0, tx_byte}, 32'h0);
    rst = 1'b0;
    acks_q.delete();
    bytes_q.delete();
    // Search restarts at 0, so requester 2 must beat requester 3.
    while (acks_q.size() == 0 && n_cmp < 100000) begin
      cycle();
      if (acks_q.size() != 0) req = 4'b0000;
      if (bytes_q.size() > 8) break;
    end
    chk("midrst_ack_count", acks_q.size(), 1);
    check_words("midrst", 1, 8'h02, 64'h3333_2222_0000_DEAD);

    for (int c = 0; c < 5; c++) cycle();
    chk("proto_dv_while_active", v_dv_active, 0);
    chk("proto_dv_two_cycles", v_dv_double, 0);
    chk("proto_ack_not_after_done", v_ack_nodone, 0);
    chk("proto_byte_sequencing", v_seq, 0);
    chk("proto_busy_window", v_busy, 0);
    chk("proto_ack_onehot", v_onehot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
